// File: rtl/pwc_pkg.sv
// Shared types and defaults for the parity window counter.
//   pwc_state_t    : accumulator FSM state (IDLE, ACCUM)
//   PWC_WINDOW_DEF : default number of samples per window
package pwc_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } pwc_state_t;

    localparam int PWC_WINDOW_DEF = 16;

endpackage

// File: rtl/pwc_run_tracker.sv
// Consecutive-ones run tracker for one window.
// Holds the current run length and the longest run seen so far in the
// window. Both outputs are registered and exclude the sample presented
// this cycle; the owner folds in the current bit when it needs a final
// value on the window-end edge.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bit_in     : sample bit
//   sample     : bit_in is a valid sample this edge
//   restart    : this sample closes the window; both runs return to 0 after it
//   clear      : abort, both runs return to 0 (sample ignored)
//   cur_run    : length of the run ending at the previous sample
//   max_run    : longest run in the window up to the previous sample
module pwc_run_tracker #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             sample,
    input  logic             restart,
    input  logic             clear,
    output logic [CNT_W-1:0] cur_run,
    output logic [CNT_W-1:0] max_run
);

    logic [CNT_W-1:0] run_nxt;
    logic [CNT_W-1:0] max_nxt;

    always_comb begin
        run_nxt = bit_in ? cur_run + CNT_W'(1) : '0;
        max_nxt = (run_nxt > max_run) ? run_nxt : max_run;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_run <= '0;
            max_run <= '0;
        end else if (clear || (sample && restart)) begin
            // Runs never carry across a window boundary.
            cur_run <= '0;
            max_run <= '0;
        end else if (sample) begin
            cur_run <= run_nxt;
            max_run <= max_nxt;
        end
    end

endmodule

// File: rtl/parity_window_counter.sv
// Parity window counter.
// Samples bit_in once per clock over back-to-back windows of WINDOW
// samples and reports, per window, the count of ones and the longest
// run of consecutive ones over a valid/ready handshake. A window that
// ends while an unaccepted result is pending is dropped and flagged in
// the sticky overrun bit.
// Optional build macro PWC_FIRST_IDX_EN adds first_idx: index of the
// first 1 in the window, or WINDOW when the window holds no ones.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   en_i                : accumulate while high; low aborts a partial window
//   bit_in              : sample bit
//   clr_i               : synchronous clear of overrun (a new drop wins)
//   res_valid/res_ready : result handshake
//   ones_cnt, max_run   : result fields, stable while res_valid && !res_ready
//   overrun             : sticky dropped-result flag
//   first_idx           : (PWC_FIRST_IDX_EN only) first-one index
module parity_window_counter
    import pwc_pkg::*;
#(
    parameter  int WINDOW = PWC_WINDOW_DEF,
    localparam int CNT_W  = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             bit_in,
    input  logic             clr_i,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] ones_cnt,
    output logic [CNT_W-1:0] max_run,
    output logic             overrun
`ifdef PWC_FIRST_IDX_EN
    ,
    output logic [CNT_W-1:0] first_idx
`endif
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

    pwc_state_t       state, state_nxt;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] ones_acc;
    logic [CNT_W-1:0] ones_now;
    logic [CNT_W-1:0] cur_run;
    logic [CNT_W-1:0] run_max;
    logic [CNT_W-1:0] run_now;
    logic [CNT_W-1:0] max_now;
    logic             sample;
    logic             abort;
    logic             win_end;
    logic             load;
    logic             drop;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en_i)  state_nxt = ACCUM;
            ACCUM:   if (!en_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // idx is always 0 in IDLE, so an enabled edge in either state takes
    // sample idx; the window closes on the sample with index WINDOW-1.
    always_comb begin
        sample  = en_i;
        abort   = (state == ACCUM) && !en_i;
        win_end = en_i && (idx == LAST_IDX);
        load    = win_end && (!res_valid || res_ready);
        drop    = win_end && res_valid && !res_ready;
    end

    // ---------------- accumulators ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            ones_acc <= '0;
        end else if (abort || win_end) begin
            idx      <= '0;
            ones_acc <= '0;
        end else if (sample) begin
            idx      <= idx + CNT_W'(1);
            ones_acc <= ones_now;
        end
    end

    pwc_run_tracker #(.CNT_W(CNT_W)) u_run (
        .clk     (clk),
        .rst_n   (rst_n),
        .bit_in  (bit_in),
        .sample  (sample),
        .restart (win_end),
        .clear   (abort),
        .cur_run (cur_run),
        .max_run (run_max)
    );

    // Window totals including the sample presented on this edge.
    always_comb begin
        ones_now = ones_acc + CNT_W'(bit_in);
        run_now  = bit_in ? cur_run + CNT_W'(1) : '0;
        max_now  = (run_now > run_max) ? run_now : run_max;
    end

    // ---------------- result / handshake ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            ones_cnt  <= '0;
            max_run   <= '0;
        end else begin
            if (load) begin
                res_valid <= 1'b1;
                ones_cnt  <= ones_now;
                max_run   <= max_now;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     overrun <= 1'b0;
        else if (drop)  overrun <= 1'b1;
        else if (clr_i) overrun <= 1'b0;
    end

`ifdef PWC_FIRST_IDX_EN
    // WINDOW doubles as the "no one seen yet" marker while accumulating.
    localparam logic [CNT_W-1:0] NO_ONE = CNT_W'(WINDOW);

    logic [CNT_W-1:0] first_acc;
    logic [CNT_W-1:0] first_now;

    always_comb begin
        first_now = (bit_in && (first_acc == NO_ONE)) ? idx : first_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                first_acc <= NO_ONE;
        else if (abort || win_end) first_acc <= NO_ONE;
        else if (sample)           first_acc <= first_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    first_idx <= '0;
        else if (load) first_idx <= first_now;
    end
`endif

endmodule

// File: tb/tb_parity_window_counter.sv
// Directed self-checking bench for parity_window_counter with WINDOW=8.
module tb_parity_window_counter;

    localparam int WINDOW = 8;
    localparam int CNT_W  = $clog2(WINDOW + 1);

    logic             clk;
    logic             rst_n;
    logic             en_i;
    logic             bit_in;
    logic             clr_i;
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] ones_cnt;
    logic [CNT_W-1:0] max_run;
    logic             overrun;
`ifdef PWC_FIRST_IDX_EN
    logic [CNT_W-1:0] first_idx;
`endif

    int errors = 0;
    int checks = 0;

    parity_window_counter #(.WINDOW(WINDOW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (en_i),
        .bit_in    (bit_in),
        .clr_i     (clr_i),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .ones_cnt  (ones_cnt),
        .max_run   (max_run),
        .overrun   (overrun)
`ifdef PWC_FIRST_IDX_EN
        ,
        .first_idx (first_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input int v, input int ones, input int mrun, input int fidx);
        chk({tag, ".valid"}, 32'(res_valid), 32'(v));
        chk({tag, ".ones"},  32'(ones_cnt),  32'(ones));
        chk({tag, ".max"},   32'(max_run),   32'(mrun));
`ifdef PWC_FIRST_IDX_EN
        chk({tag, ".first"}, 32'(first_idx), 32'(fidx));
`else
        if (fidx < 0) $display("unused first index");
`endif
    endtask

    // One enabled edge presenting bit b; returns 1 time unit after the edge.
    task automatic samp(input logic b);
        en_i   = 1'b1;
        bit_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        en_i   = 1'b0;
        bit_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic samp_vec(input logic [7:0] v, input int n);
        // Bits are presented MSB first.
        for (int i = 7; i > 7 - n; i--) samp(v[i]);
    endtask

    initial begin
        rst_n = 1'b0; en_i = 1'b0; bit_in = 1'b0; clr_i = 1'b0; res_ready = 1'b0;
        #1;
        chk_res("reset", 0, 0, 0, 0);
        chk("reset.overrun", 32'(overrun), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic window 1,1,0,1,1,1,0,1 then all-0 and all-1 windows back to back.
        res_ready = 1'b1;
        samp_vec(8'b1101_1101, 8);
        chk_res("win_basic", 1, 6, 3, 0);
        samp(1'b0);
        chk("xfer_drops_valid", 32'(res_valid), 0);
        samp_vec(8'b0000_0000, 7);
        chk_res("win_zero", 1, 0, 0, 8);
        samp_vec(8'b1111_1111, 8);
        chk_res("win_ones", 1, 8, 8, 0);
        idle_cycle();
        chk("idle_after_xfer", 32'(res_valid), 0);

        // Backpressure across two windows.
        res_ready = 1'b0;
        samp_vec(8'b1010_1000, 8);
        chk_res("bp_first", 1, 3, 1, 0);
        chk("bp_first.overrun", 32'(overrun), 0);
        samp_vec(8'b0111_0110, 8);
        chk_res("bp_hold", 1, 3, 1, 0);
        chk("bp_drop.overrun", 32'(overrun), 1);
        res_ready = 1'b1;
        idle_cycle();
        chk("bp_xfer.valid", 32'(res_valid), 0);
        chk("bp_sticky.overrun", 32'(overrun), 1);
        clr_i = 1'b1;
        idle_cycle();
        clr_i = 1'b0;
        chk("clr.overrun", 32'(overrun), 0);

        // Abort after 4 samples, then a clean all-ones window.
        samp_vec(8'b1111_0000, 4);
        en_i = 1'b0; bit_in = 1'b1;
        @(posedge clk); #1;
        chk("abort.valid", 32'(res_valid), 0);
        samp_vec(8'b1111_1111, 7);
        chk("abort_7.valid", 32'(res_valid), 0);
        samp(1'b1);
        chk_res("after_abort", 1, 8, 8, 0);

        // Consumer accepts on the very edge the next window ends.
        res_ready = 1'b0;
        samp_vec(8'b0011_0000, 7);
        chk_res("sim_hold", 1, 8, 8, 0);
        res_ready = 1'b1;
        samp(1'b0);
        chk_res("sim_load", 1, 2, 2, 2);
        chk("sim.overrun", 32'(overrun), 0);

        // Reset mid-window while a result is pending.
        res_ready = 1'b0;
        samp_vec(8'b1110_0000, 3);
        #2 rst_n = 1'b0;
        #1;
        chk_res("midreset", 0, 0, 0, 0);
        chk("midreset.overrun", 32'(overrun), 0);
        en_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        samp_vec(8'b1000_0000, 7);
        chk("post_reset_7.valid", 32'(res_valid), 0);
        samp(1'b1);
        chk_res("post_reset", 1, 2, 1, 0);
        res_ready = 1'b1;
        idle_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/parity_window_counter.md
Name: parity_window_counter

Overview:
- Downstream consumer of the registered 2-bit AND/XOR stage.
- Samples that stage's 1-bit parity output (bit_in) once per clock over fixed windows of WINDOW cycles.
- For each window it reports the count of ones and the longest run of consecutive ones.
- Results are delivered over a valid/ready handshake to the monitoring/status logic.

Parameters:
- WINDOW, 16, samples per window; legal range 2..1024.
- CNT_W, $clog2(WINDOW+1), derived localparam: width of count/run/index fields (not overridable).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en_i  in  1  enable; high = accumulate windows, low = idle/abort.
- bit_in  in  1  parity bit from upstream stage, sampled every clock while active.
- clr_i  in  1  synchronous clear of the overrun flag.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- ones_cnt  out  CNT_W  number of ones in the window.
- max_run  out  CNT_W  longest consecutive-ones run in the window.
- overrun  out  1  sticky: a window result was dropped.
- first_idx  out  CNT_W  only with PWC_FIRST_IDX_EN; see Optional Feature.

Behaviour:
- Reset (async, immediate): state IDLE; all counters 0; res_valid, ones_cnt, max_run, overrun, first_idx all 0.
- Reset mid-window discards the partial window.
- States: IDLE, ACCUM.
- IDLE, en_i=1: bit_in at this edge is sample 0. Go to ACCUM with sample index 1.
- IDLE, en_i=0: remain in IDLE.
- ACCUM, en_i=1: sample bit_in each edge and increment the sample index.
- ACCUM, en_i=0 at any edge: abort. Discard the partial window, clear the accumulators, go to IDLE, produce no result. The bit at that edge is not sampled.
- Window end is the edge that samples sample WINDOW-1:
  - result = accumulators including that sample; res_valid=1 from the next cycle (latency 1 after the last sample is presented).
  - Accumulators restart at zero. If en_i is still high, the next edge is sample 0 of the next window, with no gap cycles. State stays ACCUM.
- Run tracking: cur_run increments on 1 and resets to 0 on 0. max_run = max over the window. Runs never span a window boundary. An all-ones window gives max_run=WINDOW.
- Handshake: result fields are stable while res_valid && !res_ready. The transfer occurs on an edge with res_valid && res_ready; res_valid drops next cycle unless a new result loads on the same edge.
- Simultaneous transfer and window end: the new result loads, res_valid stays 1, no overrun.
- Window end while res_valid && !res_ready: the new result is dropped, the old one is held, and overrun is set.
- overrun: stays set until clr_i=1 or reset. If clr_i and a new drop occur on the same edge, set wins.
- No arithmetic overflow is possible, because CNT_W holds the value WINDOW.

Optional Feature:
- Macro: PWC_FIRST_IDX_EN.
- Defined: the first_idx port exists. It gives the index (0..WINDOW-1) of the first 1 in the window, or WINDOW if the window has no ones. It follows the same load/hold rules as ones_cnt; reset value 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package pwc_pkg: state enum typedef pwc_state_t {IDLE, ACCUM}; default WINDOW constant PWC_WINDOW_DEF=16.
- Sub-module pwc_run_tracker: inputs bit, clear/restart, enable; outputs cur_run and max_run. Instantiated once.
- Top module: FSM, sample index, ones counter, result registers, handshake, overrun.

Test Plan:
- Reset: assert rst_n low mid-stream → all outputs 0 immediately; no res_valid after release until a full new window completes.
- WINDOW=8, en_i=1, res_ready=1, bits 1,1,0,1,1,1,0,1 → one cycle after 8th sample res_valid=1, ones_cnt=6, max_run=3, first_idx=0.
- WINDOW=8, bits all 0 then all 1 back-to-back → results (0,0,first_idx=8) then (8,8,first_idx=0) on consecutive windows, no gap cycles.
- Backpressure: res_ready=0 across two windows (counts 3 then 5) → res_valid held with ones_cnt=3, overrun=1 after 2nd window; res_ready=1 → transfer; clr_i=1 → overrun=0.
- Abort: en_i dropped after 4 samples → no res_valid, state IDLE; re-enable with 8 ones → ones_cnt=8, proving accumulators cleared.
- Simultaneous: res_ready pulsed on the exact edge a new window ends → res_valid stays 1, new values presented, overrun stays 0.
